// File: rtl/serial_frame_logger.sv
// Multi-channel UART frame logger: snapshots NUM_CH bytes on a start edge and
// sends them (raw or ASCII hex) 8N1, MSB byte first, then a terminator char.
module serial_frame_logger #(
    parameter int          NUM_CH       = 2,
    parameter int          CLKS_PER_BIT = 10416,
    parameter int          HEX_MODE     = 0,
    parameter logic [7:0]  TERM_CHAR    = 8'h0A
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [8*NUM_CH-1:0]   i_data,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overrun
);

    localparam int NCHAR = (HEX_MODE != 0) ? 2 * NUM_CH + 1 : NUM_CH + 1;
    localparam int CBW   = $clog2(CLKS_PER_BIT);
    localparam int IW    = $clog2(NCHAR + 1);
    localparam logic [CBW-1:0] CNT_LAST = CBW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0]  IDX_LAST = IW'(NCHAR - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end else begin
            return 8'h37 + {4'h0, nib};
        end
    endfunction

    // In hex mode two consecutive character slots map onto one payload byte.
    function automatic logic [7:0] char_at(input logic [8*NUM_CH-1:0] frame,
                                           input logic [IW-1:0] idx);
        logic [7:0] sel_byte;
        int         k;
        sel_byte = 8'h00;
        k = (HEX_MODE != 0) ? int'(idx[IW-1:1]) : int'(idx);
        for (int j = 0; j < NUM_CH; j++) begin
            if (j == k) begin
                sel_byte = frame[8*(NUM_CH-1-j) +: 8];
            end
        end
        if (idx == IDX_LAST) begin
            return TERM_CHAR;
        end else if (HEX_MODE != 0) begin
            return idx[0] ? hex_ascii(sel_byte[3:0]) : hex_ascii(sel_byte[7:4]);
        end else begin
            return sel_byte;
        end
    endfunction

    state_t              state_q, state_d;
    logic [CBW-1:0]      cnt_q, cnt_d;
    logic [2:0]          bit_q, bit_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [8*NUM_CH-1:0] frame_q, frame_d;
    logic                start_q;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ovr_q, ovr_d;
    logic                start_edge;
    logic [7:0]          cur_char;

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        idx_d      = idx_q;
        frame_d    = frame_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        start_edge = i_start & ~start_q;
        ovr_d      = start_edge & busy_q;

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    frame_d = i_data;
                    idx_d   = '0;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    busy_d  = 1'b1;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_START;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Line level is derived from the next state so o_tx stays registered
        // without lagging the state machine by a cycle.
        cur_char = char_at(frame_d, idx_d);
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = cur_char[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            idx_q   <= '0;
            frame_q <= '0;
            start_q <= 1'b1;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            start_q <= i_start;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_tx      = tx_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_overrun = ovr_q;

endmodule

// File: tb/tb_serial_frame_logger.sv
// Scoreboard bench: three logger instances (raw 2-byte, hex 2-byte, raw 1-byte)
// decoded by UART line monitors and compared against queued expected frames.
module tb_serial_frame_logger;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start;
    logic [15:0] data [3];
    wire  [2:0]  tx, busy, done, ovr;

    logic [7:0]  exp_q [3][$];
    int          len_q [3][$];
    int          total = 0;
    int          bad = 0;
    int          rst_gen = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input bit ok, input int got, input int want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h t=%0t", name, got, want, $time);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        string h;
        h = "0123456789ABCDEF";
        return h[int'(n)];
    endfunction

    // Reference model: character list and busy length straight from the frame rules.
    task automatic push_expected(input int g, input logic [15:0] d);
        int nc;
        int nchars;
        logic [7:0] b;
        nc = (g == 2) ? 1 : 2;
        nchars = 0;
        for (int k = 0; k < nc; k++) begin
            b = (nc == 1) ? d[7:0] : ((k == 0) ? d[15:8] : d[7:0]);
            if (g == 1) begin
                exp_q[g].push_back(hexc(b[7:4]));
                exp_q[g].push_back(hexc(b[3:0]));
                nchars += 2;
            end else begin
                exp_q[g].push_back(b);
                nchars += 1;
            end
        end
        exp_q[g].push_back(8'h0A);
        nchars += 1;
        len_q[g].push_back(nchars * 10 * CPB);
    endtask

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : gi
            localparam int NC = (g == 2) ? 1 : 2;
            localparam int HX = (g == 1) ? 1 : 0;

            serial_frame_logger #(
                .NUM_CH(NC), .CLKS_PER_BIT(CPB), .HEX_MODE(HX), .TERM_CHAR(8'h0A)
            ) dut (
                .i_clock(clk), .i_reset(rst), .i_start(start[g]),
                .i_data(data[g][8*NC-1:0]), .o_tx(tx[g]), .o_busy(busy[g]),
                .o_done(done[g]), .o_overrun(ovr[g])
            );

            // UART decoder: mid-bit sampling, compares each character with the queue.
            initial begin : mon_char
                logic [9:0] bits;
                logic [7:0] e;
                int gen;
                forever begin
                    @(negedge clk);
                    if (tx[g] === 1'b0 && rst === 1'b0) begin
                        gen = rst_gen;
                        repeat (2) @(negedge clk);
                        bits[0] = tx[g];
                        for (int b = 1; b < 10; b++) begin
                            repeat (CPB) @(negedge clk);
                            bits[b] = tx[g];
                        end
                        if (gen == rst_gen) begin
                            if (exp_q[g].size() == 0) begin
                                check($sformatf("unexpected char inst%0d", g), 1'b0, int'(bits), 0);
                            end else begin
                                e = exp_q[g].pop_front();
                                check($sformatf("char inst%0d", g), bits === {1'b1, e, 1'b0},
                                      int'(bits), int'({1'b1, e, 1'b0}));
                            end
                        end
                    end
                end
            end

            // Frame monitor: busy length, done coincident with busy falling, no stray done.
            initial begin : mon_frame
                int cnt;
                int gen;
                int want;
                bit prev_b;
                cnt = 0; gen = 0; prev_b = 1'b0;
                forever begin
                    @(negedge clk);
                    if (busy[g] === 1'b1) begin
                        if (!prev_b) begin
                            cnt = 0;
                            gen = rst_gen;
                        end
                        cnt++;
                    end else if (prev_b && gen == rst_gen) begin
                        check($sformatf("done at busy fall inst%0d", g), done[g] === 1'b1, int'(done[g]), 1);
                        if (len_q[g].size() == 0) begin
                            check($sformatf("unexpected frame inst%0d", g), 1'b0, cnt, 0);
                        end else begin
                            want = len_q[g].pop_front();
                            check($sformatf("busy length inst%0d", g), cnt == want, cnt, want);
                        end
                    end
                    if (done[g] === 1'b1 && !(prev_b && busy[g] === 1'b0)) begin
                        check($sformatf("stray done inst%0d", g), 1'b0, 1, 0);
                    end
                    prev_b = (busy[g] === 1'b1);
                end
            end
        end
    endgenerate

    task automatic send_frame(input int gsel, input logic [15:0] d, input bit chg, input logic [15:0] nd);
        @(negedge clk);
        data[gsel] = d;
        start[gsel] = 1'b1;
        push_expected(gsel, d);
        @(negedge clk);
        start[gsel] = 1'b0;
        if (chg) begin
            repeat (9) @(negedge clk);
            data[gsel] = nd;
        end
    endtask

    task automatic wait_idle(input int gsel);
        int n;
        n = 0;
        while (busy[gsel] !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check($sformatf("idle timeout inst%0d", gsel), 1'b0, n, 2000);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        bit seen;
        rst = 1'b1;
        start = 3'b000;
        for (int i = 0; i < 3; i++) data[i] = 16'h0000;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset tx", tx[i] === 1'b1, int'(tx[i]), 1);
            check("reset busy", busy[i] === 1'b0, int'(busy[i]), 0);
            check("reset done", done[i] === 1'b0, int'(done[i]), 0);
            check("reset overrun", ovr[i] === 1'b0, int'(ovr[i]), 0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed frames: raw, hex, and payload change after accept.
        send_frame(0, 16'hA55A, 1'b0, 16'h0000); wait_idle(0);
        send_frame(1, 16'h1F0C, 1'b0, 16'h0000); wait_idle(1);
        send_frame(0, 16'h1234, 1'b1, 16'hFFFF); wait_idle(0);

        // Second edge mid-frame is rejected with a single overrun pulse.
        send_frame(0, 16'h3C5A, 1'b0, 16'h0000);
        repeat (48) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        check("overrun pulse", ovr[0] === 1'b1, int'(ovr[0]), 1);
        @(negedge clk);
        check("overrun one cycle", ovr[0] === 1'b0, int'(ovr[0]), 0);
        start[0] = 1'b0;
        wait_idle(0);

        // Start held high for 500 cycles yields one frame.
        @(negedge clk);
        data[2] = 16'h00E7;
        start[2] = 1'b1;
        push_expected(2, 16'h00E7);
        repeat (500) @(negedge clk);
        start[2] = 1'b0;
        wait_idle(2);

        // Reset mid-frame with start held across release.
        send_frame(0, 16'hC3E1, 1'b0, 16'h0000);
        repeat (58) @(negedge clk);
        rst_gen++;
        rst = 1'b1;
        start[0] = 1'b1;
        @(negedge clk);
        check("abort tx high", tx[0] === 1'b1, int'(tx[0]), 1);
        check("abort busy low", busy[0] === 1'b0, int'(busy[0]), 0);
        check("abort no done", done[0] === 1'b0, int'(done[0]), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q[0].delete();
        len_q[0].delete();
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy[0] !== 1'b0 || done[0] !== 1'b0) seen = 1'b1;
        end
        check("no frame while start held", !seen, int'(seen), 0);
        start[0] = 1'b0;
        send_frame(0, 16'h7E81, 1'b0, 16'h0000); wait_idle(0);

        // Back-to-back frames on the single-byte instance.
        send_frame(2, 16'h00A7, 1'b0, 16'h0000);
        n = 0;
        while (done[2] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("done seen", done[2] === 1'b1, int'(done[2]), 1);
        check("idle cycle tx", tx[2] === 1'b1, int'(tx[2]), 1);
        check("idle cycle busy", busy[2] === 1'b0, int'(busy[2]), 0);
        data[2] = 16'h0035;
        start[2] = 1'b1;
        push_expected(2, 16'h0035);
        @(negedge clk);
        check("b2b busy", busy[2] === 1'b1, int'(busy[2]), 1);
        check("b2b start bit", tx[2] === 1'b0, int'(tx[2]), 0);
        start[2] = 1'b0;
        wait_idle(2);

        // Random frames on random instances.
        for (int r = 0; r < 30; r++) begin
            int gs;
            logic [15:0] d;
            gs = $urandom_range(0, 2);
            d = 16'($urandom);
            send_frame(gs, d, 1'($urandom_range(0, 1)), 16'($urandom));
            wait_idle(gs);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (50) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("chars drained", exp_q[i].size() == 0, exp_q[i].size(), 0);
            check("frames drained", len_q[i].size() == 0, len_q[i].size(), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
